// File: rtl/uart_tx_buf.sv
// FIFO-buffered UART transmitter: configurable frame length, optional parity,
// one or two stop bits and line break; all bit timing counts baud ticks only.
//
// state  | meaning
// IDLE   | line marking, waiting for a tick that brings a break request or data
// BREAK  | line low while brk (at least the minimum break time), then one mark bit
// START  | start bit
// DATA   | data bits, LSB first
// PARITY | parity bit, only when enabled for this frame
// STOP   | one or two stop bits
module uart_tx_buf #(
    parameter int DEPTH    = 8,
    parameter int MAX_BITS = 9,
    parameter int OS       = 16
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_tick,
    input  logic                    i_wr_en,
    input  logic [MAX_BITS-1:0]     i_wr_data,
    input  logic [3:0]              i_frame_length,
    input  logic                    i_parity_en,
    input  logic                    i_parity_type,
    input  logic                    i_stop2,
    input  logic                    i_brk,
    input  logic                    i_ovf_clr,
    output logic                    o_tx,
    output logic                    o_tx_busy,
    output logic                    o_tx_done,
    output logic                    o_full,
    output logic                    o_empty,
    output logic [$clog2(DEPTH):0]  o_level,
    output logic                    o_overflow
);
    localparam int AW        = $clog2(DEPTH);
    localparam int BRK_TICKS = (2 + MAX_BITS) * OS;
    localparam int TW        = $clog2(BRK_TICKS);
    localparam logic [TW-1:0] BIT_LAST  = TW'(OS - 1);
    localparam logic [TW-1:0] BRK_LAST  = TW'(BRK_TICKS - 1);
    localparam logic [AW:0]   DEPTH_LVL = (AW+1)'(DEPTH);

    typedef enum logic [2:0] {IDLE, BREAK, START, DATA, PARITY, STOP} state_t;

    state_t                r_state;
    logic [MAX_BITS-1:0]   r_mem [DEPTH];
    logic [AW-1:0]         r_wptr;
    logic [AW-1:0]         r_rptr;
    logic [AW:0]           r_level;
    logic                  r_overflow;
    logic [TW-1:0]         r_tick_cnt;
    logic [3:0]            r_bit_cnt;
    logic [MAX_BITS-1:0]   r_shift;
    logic                  r_par_en;
    logic                  r_par_bit;
    logic                  r_stop2;
    logic                  r_stop_more;
    logic                  r_brk_mark;

    logic [MAX_BITS-1:0]   w_head;
    logic [MAX_BITS-1:0]   w_mask;
    logic [3:0]            w_len;
    logic                  w_par;
    logic                  w_tick_tc;
    logic                  w_frame_end;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_drop;

    assign o_level    = r_level;
    assign o_overflow = r_overflow;
    assign o_empty    = (r_level == '0);
    assign o_full     = (r_level == DEPTH_LVL);

    assign w_head      = r_mem[r_rptr];
    assign w_tick_tc   = (r_tick_cnt == '0);
    assign w_frame_end = (r_state == STOP) && i_tick && w_tick_tc && !r_stop_more;
    // A pop happens on the idle tick or on the last stop tick, never while a break is requested.
    assign w_pop       = i_tick && !o_empty && !i_brk && ((r_state == IDLE) || w_frame_end);
    assign w_push      = i_wr_en && (!o_full || w_pop);
    assign w_drop      = i_wr_en && o_full && !w_pop;

    always_comb begin
        if (i_frame_length < 4'd5)
            w_len = 4'd5;
        else if (i_frame_length > 4'(MAX_BITS))
            w_len = 4'(MAX_BITS);
        else
            w_len = i_frame_length;
        for (int i = 0; i < MAX_BITS; i++)
            w_mask[i] = (i < int'(w_len));
        w_par = (^(w_head & w_mask)) ^ i_parity_type;
    end

    always_ff @(posedge i_clk) begin
        if (w_push)
            r_mem[r_wptr] <= i_wr_data;
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + 1'b1;
            if (w_pop)
                r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
            if (w_drop)
                r_overflow <= 1'b1;
            else if (i_ovf_clr)
                r_overflow <= 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state     <= IDLE;
            o_tx        <= 1'b1;
            o_tx_busy   <= 1'b0;
            o_tx_done   <= 1'b0;
            r_tick_cnt  <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_par_en    <= 1'b0;
            r_par_bit   <= 1'b0;
            r_stop2     <= 1'b0;
            r_stop_more <= 1'b0;
            r_brk_mark  <= 1'b0;
        end else begin
            o_tx_done <= 1'b0;
            if (w_pop) begin
                o_tx_done  <= (r_state == STOP);
                r_state    <= START;
                o_tx       <= 1'b0;
                o_tx_busy  <= 1'b1;
                r_tick_cnt <= BIT_LAST;
                r_shift    <= w_head;
                r_bit_cnt  <= w_len - 4'd1;
                r_par_en   <= i_parity_en;
                r_par_bit  <= w_par;
                r_stop2    <= i_stop2;
            end else if (i_tick) begin
                if (r_state != IDLE && !w_tick_tc) begin
                    r_tick_cnt <= r_tick_cnt - 1'b1;
                end else begin
                    r_tick_cnt <= BIT_LAST;
                    case (r_state)
                        IDLE: begin
                            if (i_brk) begin
                                r_state    <= BREAK;
                                o_tx       <= 1'b0;
                                o_tx_busy  <= 1'b1;
                                r_tick_cnt <= BRK_LAST;
                                r_brk_mark <= 1'b0;
                            end else begin
                                r_tick_cnt <= '0;
                            end
                        end
                        BREAK: begin
                            if (r_brk_mark) begin
                                r_state   <= IDLE;
                                o_tx_busy <= 1'b0;
                            end else if (!i_brk) begin
                                r_brk_mark <= 1'b1;
                                o_tx       <= 1'b1;
                            end else begin
                                r_tick_cnt <= '0;
                            end
                        end
                        START: begin
                            r_state <= DATA;
                            o_tx    <= r_shift[0];
                        end
                        DATA: begin
                            if (r_bit_cnt != 4'd0) begin
                                r_bit_cnt <= r_bit_cnt - 4'd1;
                                r_shift   <= r_shift >> 1;
                                o_tx      <= r_shift[1];
                            end else if (r_par_en) begin
                                r_state <= PARITY;
                                o_tx    <= r_par_bit;
                            end else begin
                                r_state     <= STOP;
                                o_tx        <= 1'b1;
                                r_stop_more <= r_stop2;
                            end
                        end
                        PARITY: begin
                            r_state     <= STOP;
                            o_tx        <= 1'b1;
                            r_stop_more <= r_stop2;
                        end
                        STOP: begin
                            if (r_stop_more) begin
                                r_stop_more <= 1'b0;
                            end else begin
                                r_state   <= IDLE;
                                o_tx_busy <= 1'b0;
                                o_tx_done <= 1'b1;
                            end
                        end
                        default: r_state <= IDLE;
                    endcase
                end
            end
        end
    end
endmodule

// File: doc/uart_tx_buf.md
UART_TX_BUF -- requirements
Module: uart_tx_buf

Interface
REQ-001 Parameter DEPTH, default 8, sets the transmit FIFO depth in words; it SHALL be a power of 2 and at least 2.
REQ-002 Parameter MAX_BITS, default 9, sets the maximum data bits per frame; it SHALL be in the range 5..9.
REQ-003 Parameter OS, default 16, sets the number of tick pulses per bit period; it SHALL be at least 1.
REQ-004 clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  reset, asynchronous, active-low.
REQ-006 tick  input  1  baud-rate enable, one clk cycle wide; all bit timing SHALL count tick pulses only.
REQ-007 wr_en  input  1  push wr_data into the FIFO.
REQ-008 wr_data  input  MAX_BITS  frame payload, LSB transmitted first.
REQ-009 frame_length  input  4  number of data bits per frame.
REQ-010 parity_en, parity_type, stop2  input  1 each  parity on; parity odd (1) or even (0); two stop bits.
REQ-011 brk  input  1  break request.
REQ-012 ovf_clr  input  1  clears the overflow flag.
REQ-013 tx  output  1  serial line, registered.
REQ-014 tx_busy  output  1  high in every state except IDLE.
REQ-015 tx_done  output  1  one-cycle pulse at the end of a frame.
REQ-016 full, empty  output  1 each  FIFO status.
REQ-017 level  output  clog2(DEPTH)+1  FIFO occupancy.
REQ-018 overflow  output  1  sticky flag, set when a write is dropped.

Function
REQ-019 FIFO write: wr_en with full=0 stores the word; wr_en with full=1 drops the word and sets overflow.
REQ-020 Exception to REQ-019: wr_en while full, in the same cycle as a FIFO pop, SHALL be accepted; level stays at DEPTH and overflow is not set.
REQ-021 Pointers SHALL wrap modulo DEPTH; level SHALL never exceed DEPTH or go below 0.
REQ-022 overflow SHALL clear on ovf_clr; if ovf_clr and a dropped write coincide, set wins.
REQ-023 The FSM SHALL have exactly the states IDLE, BREAK, START, DATA, PARITY and STOP.
REQ-024 IDLE behaviour: tx=1; on a tick with brk=1 the FSM goes to BREAK; otherwise, on a tick with empty=0, it pops the head word and goes to START. brk has priority over FIFO data.
REQ-025 At the pop, frame_length, parity_en, parity_type and stop2 SHALL be latched; changes during the frame have no effect.
REQ-026 Latched length SHALL be clamped: a value below 5 is used as 5; a value above MAX_BITS is used as MAX_BITS.
REQ-027 Each bit SHALL last exactly OS ticks; tx changes only in the cycle after a bit-boundary tick.
REQ-028 Bit sequence: START outputs tx=0 for 1 bit; DATA outputs N data bits, LSB first; PARITY outputs 1 bit, only if parity_en; STOP outputs tx=1 for 1 bit, or 2 bits if stop2.
REQ-029 Parity bit SHALL equal the XOR of the N transmitted bits, inverted when parity_type=1; bits of wr_data above N SHALL be ignored.
REQ-030 tx_done SHALL pulse in the cycle the final stop bit ends.
REQ-031 In that same cycle, if empty=0 and brk=0, the FSM SHALL pop and enter START directly, with no idle bit; otherwise it goes to IDLE.
REQ-032 Frame length in ticks SHALL be (1+N+P+S)*OS, where P is 1 when parity is enabled (else 0) and S is 1 or 2 stop bits.
REQ-033 BREAK behaviour: tx=0 while brk=1, for a minimum of (2+MAX_BITS)*OS ticks; once brk=0 and the minimum is met, tx=1 for one bit period, then IDLE. tx_done SHALL NOT pulse for a break.
REQ-034 brk asserted mid-frame SHALL be ignored until the frame, including its stop bits, completes.

Reset
REQ-035 While reset=0, asynchronously: FSM=IDLE, tx=1, tx_busy=0, tx_done=0, level=0, empty=1, full=0, overflow=0, and all bit and tick counters are 0.
REQ-036 Reset mid-frame SHALL abort the frame immediately (tx=1) and discard all FIFO contents.
REQ-037 After reset release, no frame SHALL start before the first tick that sees empty=0.

Verification
REQ-038 OS=16, length=8, parity off, 1 stop; write 0xA5 -> tx: 0, then 1,0,1,0,0,1,0,1, then 1; 160 ticks total; one tx_done pulse.
REQ-039 Length=7, parity even; write 0x35 -> data bits 1,0,1,0,1,1,0, parity bit 0; length=7 with parity odd -> parity bit 1.
REQ-040 DEPTH=4, tx idle with tick held low; 5 writes -> full=1, level=4, overflow=1, 5th word absent; then ovf_clr -> overflow=0.
REQ-041 Two words queued, stop2=1 -> second start bit immediately follows the 2nd stop bit with no idle gap; exactly 2 tx_done pulses.
REQ-042 frame_length=3 -> 5 data bits sent; frame_length=12 with MAX_BITS=9 -> 9 data bits sent.
REQ-043 brk asserted mid-frame -> frame completes unchanged, then tx=0 for at least 11*OS ticks, then 1 mark bit, then IDLE; reset mid-frame -> tx=1 and level=0 immediately.
